// File: rtl/fmul_pkg.sv
// fmul_pkg: shared constants, result record and packing helper for the
// half-precision multiplier back end.
//   EXP_W/MAN_W/HALF_W   : binary16 field widths
//   EXP_INF/EXP_ZERO     : saturated exponent codes
//   FLAG_OVF_BIT/UNF_BIT : bit positions inside the 2-bit flag field
//   result_t             : {flags, data} record stored in the result FIFO
//   pack_result()        : converts multiplier fields + exceptions to binary16
package fmul_pkg;

  localparam int EXP_W        = 5;
  localparam int MAN_W        = 10;
  localparam int HALF_W       = 16;
  localparam int FLAG_W       = 2;
  localparam int RESULT_W     = FLAG_W + HALF_W;
  localparam int FLAG_OVF_BIT = 1;
  localparam int FLAG_UNF_BIT = 0;

  localparam logic [EXP_W-1:0] EXP_INF  = 5'b11111;
  localparam logic [EXP_W-1:0] EXP_ZERO = 5'b00000;
  localparam logic [MAN_W-1:0] MAN_ZERO = 10'b0000000000;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [HALF_W-1:0] data;
  } result_t;

  // Overflow takes priority over underflow: a result flagged both ways is
  // reported as infinity, never as zero.
  function automatic result_t pack_result(
    input logic             sign,
    input logic [EXP_W-1:0] expo,
    input logic [MAN_W-1:0] mant,
    input logic             ovf,
    input logic             unf
  );
    result_t r;
    r.flags = 2'b00;
    if (ovf) begin
      r.data               = {sign, EXP_INF, MAN_ZERO};
      r.flags[FLAG_OVF_BIT] = 1'b1;
    end else if (unf) begin
      r.data               = {sign, EXP_ZERO, MAN_ZERO};
      r.flags[FLAG_UNF_BIT] = 1'b1;
    end else begin
      r.data = {sign, expo, mant};
    end
    return r;
  endfunction

endpackage

// File: rtl/fmul_result_buffer_if.sv
// fmul_result_buffer_if: producer-side and consumer-side handshake bundle of
// the result buffer.
//   in_*  : multiplier result + exceptions, valid/ready toward the buffer
//   out_* : packed binary16 head entry + flags, valid/ready toward consumer
// Modports: slave = the buffer, master = the environment driving it.
interface fmul_result_buffer_if;
  import fmul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_Sign;
  logic [EXP_W-1:0]  in_Exponent;
  logic [MAN_W-1:0]  in_Mantissa;
  logic              in_Overflow;
  logic              in_Underflow;
  logic              out_valid;
  logic              out_ready;
  logic [HALF_W-1:0] out_Data;
  logic [FLAG_W-1:0] out_Flags;

  modport slave (
    input  in_valid, in_Sign, in_Exponent, in_Mantissa, in_Overflow, in_Underflow,
    output in_ready,
    output out_valid, out_Data, out_Flags,
    input  out_ready
  );

  modport master (
    output in_valid, in_Sign, in_Exponent, in_Mantissa, in_Overflow, in_Underflow,
    input  in_ready,
    input  out_valid, out_Data, out_Flags,
    output out_ready
  );

endinterface

// File: rtl/fmul_result_fifo.sv
// fmul_result_fifo: DEPTH-entry register FIFO with occupancy counter.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   push, pop  : write / read strobes (qualified internally against full/empty)
//   wr_data    : entry to write at the write pointer
//   rd_data    : entry at the read pointer (head), no fall-through
//   full/empty : derived from the occupancy counter
module fmul_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full    = (occ_q == OCC_FULL);
  assign empty   = (occ_q == {OCC_W{1'b0}});
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign push_ok_s = push & (~full | pop);
  assign pop_ok_s  = pop & ~empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset flushes every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/fmul_result_buffer.sv
// fmul_result_buffer: packs multiplier results into binary16 with exception
// saturation, queues them in a small FIFO and tracks exception statistics.
//   clk, reset   : clock, asynchronous active-low reset
//   bus (slave)  : in_* result handshake from multiplier, out_* to consumer
//   ovf_count    : saturating count of accepted overflow results
//   unf_count    : saturating count of accepted underflow results
//   drop_sticky  : set when a valid result met a full FIFO
//   count_clear  : synchronous clear of counters and drop_sticky
module fmul_result_buffer
  import fmul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  fmul_result_buffer_if.slave    bus,
  output logic [CNT_W-1:0]       ovf_count,
  output logic [CNT_W-1:0]       unf_count,
  output logic                   drop_sticky,
  input  logic                   count_clear
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  result_t          packed_s;
  result_t          head_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             in_ready_s;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0] unf_q, unf_d;
  logic             drop_q, drop_d;

  // Pack the incoming result before it is written to the FIFO.
  always_comb begin
    packed_s = pack_result(bus.in_Sign, bus.in_Exponent, bus.in_Mantissa,
                           bus.in_Overflow, bus.in_Underflow);
  end

  // A full FIFO still accepts when its head is being taken the same cycle.
  assign pop_s      = ~empty_s & bus.out_ready;
  assign in_ready_s = ~full_s | pop_s;
  assign push_s     = bus.in_valid & in_ready_s;

  fmul_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RESULT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (packed_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = ~empty_s;
  assign bus.out_Data  = head_s.data;
  assign bus.out_Flags = head_s.flags;

  assign ovf_count   = ovf_q;
  assign unf_count   = unf_q;
  assign drop_sticky = drop_q;

  // Exception counters and drop flag; clear overrides any same-cycle event.
  always_comb begin
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    drop_d = drop_q;
    if (count_clear) begin
      ovf_d  = {CNT_W{1'b0}};
      unf_d  = {CNT_W{1'b0}};
      drop_d = 1'b0;
    end else begin
      if (push_s && packed_s.flags[FLAG_OVF_BIT] && (ovf_q != CNT_MAX)) begin
        ovf_d = ovf_q + CNT_W'(1);
      end else begin
        ovf_d = ovf_q;
      end
      if (push_s && packed_s.flags[FLAG_UNF_BIT] && (unf_q != CNT_MAX)) begin
        unf_d = unf_q + CNT_W'(1);
      end else begin
        unf_d = unf_q;
      end
      if (bus.in_valid && !in_ready_s) begin
        drop_d = 1'b1;
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q  <= {CNT_W{1'b0}};
      unf_q  <= {CNT_W{1'b0}};
      drop_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_fmul_result_buffer.sv
// Scoreboard bench for fmul_result_buffer: the stimulus pushes hand-computed
// expected entries into a queue, an independent monitor pops and compares
// whenever the DUT hands an entry to the consumer.
module tb_fmul_result_buffer;
  import fmul_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             count_clear = 1'b0;
  logic [CNT_W-1:0] ovf_count;
  logic [CNT_W-1:0] unf_count;
  logic             drop_sticky;

  fmul_result_buffer_if bus ();

  fmul_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .ovf_count   (ovf_count),
    .unf_count   (unf_count),
    .drop_sticky (drop_sticky),
    .count_clear (count_clear)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] exp_q [$];
  logic [17:0] mon_e;
  int          m_ovf = 0;
  int          m_unf = 0;
  logic        m_drop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: a pop happens on the next rising edge when valid & ready now.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("out_valid", bus.out_valid, exp_q.size() > 0);
        if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("out_Data", bus.out_Data, mon_e[15:0]);
          chk("out_Flags", bus.out_Flags, mon_e[17:16]);
        end
      end
    end
  end

  // One cycle of input; called at posedge+1, returns at the next posedge+1.
  task automatic drive(input logic s, input logic [4:0] e, input logic [9:0] m,
                       input logic o, input logic u,
                       input logic [15:0] xd, input logic [1:0] xf);
    logic acc;
    bus.in_valid     = 1'b1;
    bus.in_Sign      = s;
    bus.in_Exponent  = e;
    bus.in_Mantissa  = m;
    bus.in_Overflow  = o;
    bus.in_Underflow = u;
    acc = (exp_q.size() < DEPTH) || (bus.out_ready && exp_q.size() > 0);
    @(negedge clk);
    chk("in_ready", bus.in_ready, acc);
    @(posedge clk);
    if (acc) exp_q.push_back({xf, xd});
    if (count_clear) begin
      m_ovf = 0; m_unf = 0; m_drop = 1'b0;
    end else begin
      if (acc && xf == 2'b10 && m_ovf < CMAX) m_ovf++;
      if (acc && xf == 2'b01 && m_unf < CMAX) m_unf++;
      if (!acc) m_drop = 1'b1;
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    chk({tag, "_ovf"}, ovf_count, m_ovf);
    chk({tag, "_unf"}, unf_count, m_unf);
    chk({tag, "_drop"}, drop_sticky, m_drop);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic clear_counts();
    count_clear = 1'b1;
    @(posedge clk);
    m_ovf = 0; m_unf = 0; m_drop = 1'b0;
    #1;
    count_clear = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_Sign = 1'b0; bus.in_Exponent = 5'd0;
    bus.in_Mantissa = 10'd0; bus.in_Overflow = 1'b0; bus.in_Underflow = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_Data", bus.out_Data, 16'h0000);
    chk("rst_out_Flags", bus.out_Flags, 2'b00);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_counts", {ovf_count, unf_count, drop_sticky}, 17'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Packing: normal, overflow (wins over underflow), underflow
    bus.out_ready = 1'b1;
    drive(1'b1, 5'b00100, 10'b0000010000, 1'b0, 1'b0, 16'h9010, 2'b00);
    drive(1'b0, 5'b01010, 10'h2AA,        1'b1, 1'b1, 16'h7C00, 2'b10);
    check_counts("ovf1");
    drive(1'b1, 5'b00111, 10'h123,        1'b0, 1'b1, 16'h8000, 2'b01);
    check_counts("unf1");
    drive(1'b0, 5'b11110, 10'h3FF,        1'b0, 1'b0, 16'h7BFF, 2'b00);
    drive(1'b1, 5'b00011, 10'h155,        1'b1, 1'b0, 16'hFC00, 2'b10);
    drive(1'b0, 5'b10101, 10'h001,        1'b0, 1'b1, 16'h0000, 2'b01);
    drive(1'b0, 5'b01111, 10'h000,        1'b0, 1'b0, 16'h3C00, 2'b00);
    drain();
    check_counts("mix");

    // Full / drop: five pushes with the consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      drive(1'b0, 5'b00000, 10'(i), 1'b0, 1'b0, 16'(i), 2'b00);
    check_counts("drop");
    drain();
    clear_counts();
    check_counts("clr");

    // Full plus simultaneous pop: push accepted, no drop, still full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      drive(1'b1, 5'b10000, 10'(16 * i), 1'b0, 1'b0, 16'hC000 | 16'(16 * i), 2'b00);
    bus.out_ready = 1'b1;
    drive(1'b0, 5'b11100, 10'h0F0, 1'b0, 1'b0, 16'h70F0, 2'b00);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("still_full", bus.in_ready, 1'b0);
    chk("swap_no_drop", drop_sticky, 1'b0);
    @(posedge clk);
    #1;
    drain();

    // Counter saturation, then clear colliding with an overflow push
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++)
      drive(1'b0, 5'b00001, 10'h001, 1'b1, 1'b0, 16'h7C00, 2'b10);
    check_counts("sat");
    chk("sat_255", ovf_count, 8'd255);
    count_clear = 1'b1;
    drive(1'b1, 5'b00001, 10'h001, 1'b1, 1'b0, 16'hFC00, 2'b10);
    count_clear = 1'b0;
    check_counts("clr_wins");
    drain();

    // Reset mid-stream with three entries queued
    bus.out_ready = 1'b0;
    drive(1'b0, 5'b00010, 10'h011, 1'b0, 1'b0, 16'h0811, 2'b00);
    drive(1'b0, 5'b00010, 10'h022, 1'b1, 1'b0, 16'h7C00, 2'b10);
    drive(1'b0, 5'b00010, 10'h033, 1'b0, 1'b1, 16'h0000, 2'b01);
    @(posedge clk);
    #3;
    reset = 1'b0;
    exp_q.delete();
    m_ovf = 0; m_unf = 0; m_drop = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_out_Data", bus.out_Data, 16'h0000);
    chk("midrst_counts", {ovf_count, unf_count, drop_sticky}, 17'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drive(1'b1, 5'b11111, 10'h3FF, 1'b0, 1'b0, 16'hFFFF, 2'b00);
    drain();
    check_counts("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmul_result_buffer.md
# fmul_result_buffer

Downstream stage of the pipelined half-precision multiplier. Takes its sign/exponent/mantissa result and overflow/underflow flags, packs them into a 16-bit IEEE-754 binary16 word with exception saturation, and queues results in a small FIFO with a valid/ready handshake toward the consumer. Per-exception counters and a sticky drop flag are kept, because the multiplier pipeline cannot stall.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- CNT_W, 8, width of exception counters
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- in_valid  in  1  multiplier result valid this cycle
- in_ready  out  1  buffer can accept this cycle
- in_Sign  in  1  result sign
- in_Exponent  in  5  result biased exponent
- in_Mantissa  in  10  result fraction
- in_Overflow  in  1  multiplier Exponent_Overflow
- in_Underflow  in  1  multiplier Exponent_Underflow
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_Data  out  16  packed binary16 {sign, exp, mant}
- out_Flags  out  2  {overflow, underflow} of head entry
- ovf_count  out  CNT_W  accepted overflow results, saturating
- unf_count  out  CNT_W  accepted underflow results, saturating
- drop_sticky  out  1  a valid result was lost to a full FIFO
- count_clear  in  1  synchronous clear of counters and drop_sticky

## Operation
- Packing (combinational, before FIFO write):
  - in_Overflow=1: {in_Sign, 5'b11111, 10'b0} (signed infinity); flags 2'b10, even if in_Underflow=1 (overflow wins).
  - in_Underflow=1 only: {in_Sign, 5'b00000, 10'b0} (signed zero); flags 2'b01.
  - Neither: {in_Sign, in_Exponent, in_Mantissa}; flags 2'b00. No rounding or renormalisation.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = !full | pop, so push and pop in the same cycle while full are both performed.
- in_valid & !in_ready: result discarded, drop_sticky set the next edge, FIFO unchanged.
- Simultaneous push/pop: occupancy unchanged, both pointers advance.
- Pointers are PTR_W = log2(DEPTH) bits and wrap modulo DEPTH. full/empty are derived from an occupancy counter (0..DEPTH).
- Counters increment only on accepted pushes with the matching flag, and saturate at 2^CNT_W−1.
- count_clear=1: counters and drop_sticky go to 0 that edge. Clear wins over a same-cycle increment or drop. FIFO contents are unaffected.

## Timing
- Reset (reset=0, async): pointers, occupancy, all storage, counters and drop_sticky go to 0. out_valid=0, out_Data=16'h0000, out_Flags=2'b00, in_ready=1.
- Reset mid-operation flushes all queued entries immediately. Entries are not recovered.
- Latency: a push at edge N gives out_valid=1 with that entry from edge N onward (visible the cycle after in_valid was presented). No fall-through.
- out_Data/out_Flags are the head entry and stay stable while out_valid & !out_ready.
- Empty: out_valid=0. out_Data shows storage at the read pointer and is don't-care for the consumer.
- Throughput: one push and one pop per cycle.

## Structure
- Shared package fmul_pkg: EXP_W=5, MAN_W=10, HALF_W=16, EXP_INF=5'b11111, EXP_ZERO=5'b00000, flag bit positions.
- One sub-module: fmul_result_fifo (parameterised DEPTH/width, occupancy, pointers, full/empty). The packer, counters and sticky logic sit in the top.

## Test plan
- Normal: in_Sign=1, exp=00100, mant=0000010000, no flags, out_ready=1 → next cycle out_valid=1, out_Data=16'h9010, out_Flags=00.
- Overflow: in_Sign=0 with in_Overflow=1 and in_Underflow=1 → out_Data=16'h7C00, out_Flags=10, ovf_count=1, unf_count=0.
- Underflow: in_Sign=1, in_Underflow=1 → out_Data=16'h8000, out_Flags=01, unf_count=1.
- Full/drop: out_ready=0, push 5 results (DEPTH=4) → in_ready=0 after the 4th, drop_sticky=1, then drain with out_ready=1 → exactly the first 4 results appear in order.
- Full plus simultaneous pop: FIFO full, out_ready=1, in_valid=1 → push accepted, drop_sticky stays 0, occupancy stays 4.
- Reset/clear: 300 overflow pushes → ovf_count=255. Assert count_clear together with an overflow push → ovf_count=0. Drive reset=0 mid-stream with 3 entries queued → out_valid=0 immediately, in_ready=1.
